rv32v_vreg_file_mp: RTL
=======================

Name: rv32v_vreg_file_mp

Overview:
- Multi-port, multi-lane vector register file for the RV32V pipeline: 32 architectural vector registers of VLENB bytes each.
- Provides READ_PORTS registered read ports and WRITE_PORTS write ports, each LANES elements wide.
- Adds over the previous generation: SEW-scaled byte addressing, vl tail suppression, mask-bit write mode, v0 mask extraction, write-to-read bypass and fixed-priority write-collision resolution.
- Sits between decode (reads) and writeback (writes).

Parameters:
- LANES, 2, elements accessed per port per cycle
- READ_PORTS, 1, number of independent read ports (each reads vs1/vs2/vs3)
- WRITE_PORTS, 1, number of write ports; a higher index has higher priority
- VLENB, 16, bytes per vector register (power of 2, 8..64)
- OFF_W, $clog2(VLENB*8), element-offset width (large enough for bit offsets of mask registers)

Ports:
- CLK, input, 1, clock
- nRST, input, 1, asynchronous active-low reset
- rd_en, input, READ_PORTS, read request per port
- rs_sel, input, READ_PORTS x 3 x 5, register numbers for vs1, vs2, vs3
- rs_sew, input, READ_PORTS x 3 x 2, element width per operand: 0=8b, 1=16b, 2=32b
- rs_off, input, READ_PORTS x 3 x LANES x OFF_W, element index per lane
- rs_data, output, READ_PORTS x 3 x LANES x 32, zero-extended element data
- rs_mask, output, READ_PORTS x LANES, v0 bit at lane offset (vs2 offset)
- rd_valid, output, READ_PORTS, rs_data is valid this cycle
- wen, input, WRITE_PORTS x LANES, per-lane write enable
- wd, input, WRITE_PORTS x 5, destination register
- w_eew, input, WRITE_PORTS x 2, write element width
- w_off, input, WRITE_PORTS x LANES x OFF_W, element index per lane
- w_data, input, WRITE_PORTS x LANES x 32, write data (low bits used)
- w_vl, input, WRITE_PORTS x (OFF_W+1), active vector length
- single_bit_write, input, WRITE_PORTS, write bit w_data[0] at bit index w_off
- w_collide, output, 1, pulses when two write lanes target the same byte in one cycle

Behaviour:
- Storage: 32 x VLENB bytes in flops. Reset clears all bytes to 0.
- Reset values: rs_data 0, rs_mask 0, rd_valid 0, w_collide 0.
- Byte address = off << sew. An element occupies 1, 2 or 4 bytes, little-endian.
- Read: 1-cycle latency. Operands are sampled when rd_en[p]=1; rs_data, rs_mask and rd_valid update on the next CLK edge. With rd_en=0, rd_valid drops to 0 and rs_data holds its previous value.
- Out-of-range read (byte address + size > VLENB) returns 0 for that lane.
- rs_mask[p][l] = bit (vs2 offset of lane l) of v0, taken from the bit-addressed view of v0 (not SEW scaled). A bit index ≥ VLENB*8 returns 0.
- Write: committed at the CLK edge. A lane writes only if all of the following hold:
  - wen=1
  - off < w_vl (tail undisturbed)
  - the address is in range
- Suppressed lanes leave storage unchanged.
- single_bit_write: the write modifies only bit w_off of register wd. The write is suppressed if w_off ≥ w_vl or w_off ≥ VLENB*8.
- Bypass: a read sampled in the same cycle as a write to the same register/byte returns the newly written byte. Bypass resolution is per byte, so partially overlapping elements merge new and old bytes.
- Collision: when multiple active lanes/ports write the same byte in one cycle:
  - the highest port index wins
  - within a port, the highest lane wins
  - w_collide=1 on the following cycle (registered)
- Bypass always uses the winning byte.
- Writes to v0 affect rs_mask in the cycle sampled after the write, or in the same sampling cycle via bypass.
- nRST asserted mid-operation clears storage and outputs immediately. A write in flight on the reset edge is lost.
- No stalls; all ports are accepted every cycle.

Test Plan:
- Reset: assert nRST=0 mid-traffic → all rs_data 0 and rd_valid 0 immediately; a subsequent read of v5 off 0 returns 0x0.
- SEW write/read: write v3 eew=16b lane0 off=1 data 0xBEEF, lane1 off=2 data 0x1234. Next cycle read sew=8b off 2,3 → 0xEF, 0xBE; read sew=32b off 1 → 0x00001234.
- Tail suppression: w_vl=3, wen lanes at off 2 and 3 with data 0xAA/0xBB, sew=8 → only byte 2 written; byte 3 remains 0.
- Mask path: single_bit_write to v0 at bit 9 with data 1, vl=16. Next cycle read with vs2 off 9 → rs_mask=1; off 8 → 0.
- Bypass: in the same cycle, write v7 off 0 = 0xCAFEF00D (32b) and read v7 off 0 → rs_data=0xCAFEF00D next cycle.
- Collision: port0 lane0 and port1 lane1 both write v2 byte 4 with 0x11/0x22 → byte 4 = 0x22, w_collide=1 for one cycle.

Source files
------------

// File: rtl/rv32v_vreg_file_mp.sv
// Multi-port, multi-lane RV32V vector register file.
// 32 registers of VLENB bytes held as byte flops. Writes from all ports are
// merged combinationally into mem_next in priority order (higher port, then
// higher lane, is applied last and wins). Reads sample mem_next, which gives
// per-byte write-to-read bypass with the winning byte for free.
module rv32v_vreg_file_mp #(
   parameter int LANES       = 2,
   parameter int READ_PORTS  = 1,
   parameter int WRITE_PORTS = 1,
   parameter int VLENB       = 16,
   parameter int OFF_W       = $clog2(VLENB*8)
) (
   input  logic                                   CLK,
   input  logic                                   nRST,
   input  logic [READ_PORTS-1:0]                  rd_en,
   input  logic [READ_PORTS*3*5-1:0]              rs_sel,
   input  logic [READ_PORTS*3*2-1:0]              rs_sew,
   input  logic [READ_PORTS*3*LANES*OFF_W-1:0]    rs_off,
   output logic [READ_PORTS*3*LANES*32-1:0]       rs_data,
   output logic [READ_PORTS*LANES-1:0]            rs_mask,
   output logic [READ_PORTS-1:0]                  rd_valid,
   input  logic [WRITE_PORTS*LANES-1:0]           wen,
   input  logic [WRITE_PORTS*5-1:0]               wd,
   input  logic [WRITE_PORTS*2-1:0]               w_eew,
   input  logic [WRITE_PORTS*LANES*OFF_W-1:0]     w_off,
   input  logic [WRITE_PORTS*LANES*32-1:0]        w_data,
   input  logic [WRITE_PORTS*(OFF_W+1)-1:0]       w_vl,
   input  logic [WRITE_PORTS-1:0]                 single_bit_write,
   output logic                                   w_collide
);

   localparam int BA_W = $clog2(VLENB);
   localparam int BITS = VLENB*8;
   localparam int RP_W = 3*LANES*32;

   logic [7:0] mem      [32][VLENB];
   logic [7:0] mem_next [32][VLENB];
   logic       touched  [32][VLENB];
   logic       collide_d;
   logic [READ_PORTS*RP_W-1:0]     rdata_d;
   logic [READ_PORTS*LANES-1:0]    rmask_d;

   // Element size in bytes; the reserved encoding 3 is treated as 32b.
   function automatic int elem_bytes(input logic [1:0] s);
      case (s)
         2'd0:    elem_bytes = 1;
         2'd1:    elem_bytes = 2;
         default: elem_bytes = 4;
      endcase
   endfunction

   // Apply all qualified write lanes in ascending priority; flag repeated bytes.
   always_comb begin
      logic [4:0]      r;
      logic [31:0]     d;
      logic [BA_W-1:0] ba;
      int              off, vl, sz, base;
      r         = '0;
      d         = '0;
      ba        = '0;
      off       = 0;
      vl        = 0;
      sz        = 1;
      base      = 0;
      mem_next  = mem;
      touched   = '{default: '{default: 1'b0}};
      collide_d = 1'b0;
      for (int w = 0; w < WRITE_PORTS; w++) begin
         for (int l = 0; l < LANES; l++) begin
            r    = wd[w*5 +: 5];
            d    = w_data[(w*LANES+l)*32 +: 32];
            off  = 32'(w_off[(w*LANES+l)*OFF_W +: OFF_W]);
            vl   = 32'(w_vl[w*(OFF_W+1) +: OFF_W+1]);
            sz   = elem_bytes(w_eew[w*2 +: 2]);
            base = off * sz;
            if (wen[w*LANES+l] && (off < vl)) begin
               if (single_bit_write[w]) begin
                  // Mask writes address bits directly, no SEW scaling.
                  if (off < BITS) begin
                     ba = BA_W'(off >> 3);
                     if (touched[r][ba]) collide_d = 1'b1;
                     touched[r][ba] = 1'b1;
                     mem_next[r][ba][3'(off)] = d[0];
                  end
               end else if (base + sz <= VLENB) begin
                  for (int k = 0; k < 4; k++) begin
                     if (k < sz) begin
                        ba = BA_W'(base + k);
                        if (touched[r][ba]) collide_d = 1'b1;
                        touched[r][ba] = 1'b1;
                        mem_next[r][ba] = 8'(d >> (8*k));
                     end
                  end
               end
            end
         end
      end
   end

   // Gather read elements and v0 mask bits from the post-write image.
   always_comb begin
      logic [4:0]  r;
      logic [31:0] val;
      int          off, sz, base;
      r       = '0;
      val     = '0;
      off     = 0;
      sz      = 1;
      base    = 0;
      rdata_d = '0;
      rmask_d = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         for (int o = 0; o < 3; o++) begin
            for (int l = 0; l < LANES; l++) begin
               r    = rs_sel[(p*3+o)*5 +: 5];
               off  = 32'(rs_off[((p*3+o)*LANES+l)*OFF_W +: OFF_W]);
               sz   = elem_bytes(rs_sew[(p*3+o)*2 +: 2]);
               base = off * sz;
               val  = '0;
               if (base + sz <= VLENB) begin
                  for (int k = 0; k < 4; k++) begin
                     if (k < sz) val = val | (32'(mem_next[r][BA_W'(base + k)]) << (8*k));
                  end
               end
               rdata_d[((p*3+o)*LANES+l)*32 +: 32] = val;
            end
         end
         for (int l = 0; l < LANES; l++) begin
            off = 32'(rs_off[((p*3+1)*LANES+l)*OFF_W +: OFF_W]);
            if (off < BITS) rmask_d[p*LANES+l] = mem_next[0][BA_W'(off >> 3)][3'(off)];
         end
      end
   end

   // Register storage; a write coinciding with reset is dropped.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < VLENB; b++) mem[r][b] <= '0;
         end
      end else begin
         mem <= mem_next;
      end
   end

   // Read output registers hold their data while a port is idle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rs_data   <= '0;
         rs_mask   <= '0;
         rd_valid  <= '0;
         w_collide <= 1'b0;
      end else begin
         rd_valid  <= rd_en;
         w_collide <= collide_d;
         for (int p = 0; p < READ_PORTS; p++) begin
            if (rd_en[p]) begin
               rs_data[p*RP_W +: RP_W]   <= rdata_d[p*RP_W +: RP_W];
               rs_mask[p*LANES +: LANES] <= rmask_d[p*LANES +: LANES];
            end
         end
      end
   end

endmodule
